mp_pf_icache_ctrl_slave: RTL and testbench

Cache-side responder for the multi-port prefetching instruction-cache control bus. It accepts bypass, full-flush, selective-flush and prefetch requests from the cluster control unit and sequences them onto the cache's tag-invalidate and refill-request ports. It returns the per-port bypass acknowledges and the flush, selective-flush and prefetch completion pulses. It sits inside the shared multi-port icache, between the control-bus Slave modport and the tag array and refill engine.

---
 rtl/icache_ctrl_slave_pkg.sv | 33 +++
 rtl/icache_pf_sequencer.sv | 84 ++++++++
 rtl/mp_pf_icache_ctrl_slave.sv | 176 +++++++++++++++++
 tb/tb_mp_pf_icache_ctrl_slave.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_ctrl_slave_pkg.sv
// ============================================================================
// Module      : icache_ctrl_slave_pkg
// Description : Shared types and helpers for the icache control-bus responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_ctrl_slave_pkg;

    localparam int CNT_W = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_SEL   = 3'd2,
        ST_PF    = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_FLUSH = 2'd1,
        OP_SEL   = 2'd2,
        OP_PF    = 2'd3
    } op_e;

    function automatic int line_off_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

endpackage

`default_nettype wire

// File: rtl/icache_pf_sequencer.sv
// ============================================================================
// Module      : icache_pf_sequencer
// Description : Prefetch line address / issued / completed counters with an
//               outstanding-fetch limit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_pf_sequencer
    import icache_ctrl_slave_pkg::*;
#(
    parameter int LINE_BYTES   = 16,
    parameter int MAX_PF_OUTST = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] addr_i,
    input  logic [7:0]  size_i,
    input  logic        en_i,
    input  logic        fetch_gnt_i,
    input  logic        fetch_done_i,
    output logic        fetch_req_o,
    output logic [31:0] fetch_addr_o,
    output logic        finished_o
);

    localparam logic [31:0]      STEP     = 32'(LINE_BYTES);
    localparam logic [31:0]      MASK     = ~(32'(LINE_BYTES) - 32'd1);
    localparam logic [CNT_W-1:0] MAX_OUT  = CNT_W'(MAX_PF_OUTST);

    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] completed_q, completed_d;
    logic [CNT_W-1:0] size_q, size_d;
    logic [CNT_W-1:0] outst;
    logic             req;

    always_comb begin
        addr_d      = addr_q;
        issued_d    = issued_q;
        completed_d = completed_q;
        size_d      = size_q;
        outst       = issued_q - completed_q;
        req         = en_i && (issued_q < size_q) && (outst < MAX_OUT);

        if (start_i) begin
            addr_d      = addr_i & MASK;
            size_d      = CNT_W'(size_i);
            issued_d    = '0;
            completed_d = '0;
        end else begin
            if (req && fetch_gnt_i) begin
                addr_d   = addr_q + STEP;
                issued_d = issued_q + 1'b1;
            end
            // Stray completions outside an active prefetch are dropped.
            if (en_i && fetch_done_i && (completed_q < issued_q)) begin
                completed_d = completed_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q      <= '0;
            issued_q    <= '0;
            completed_q <= '0;
            size_q      <= '0;
        end else begin
            addr_q      <= addr_d;
            issued_q    <= issued_d;
            completed_q <= completed_d;
            size_q      <= size_d;
        end
    end

    assign fetch_req_o  = req;
    assign fetch_addr_o = addr_q;
    assign finished_o   = (completed_q == size_q);

endmodule

`default_nettype wire

// File: rtl/mp_pf_icache_ctrl_slave.sv
// ============================================================================
// Module      : mp_pf_icache_ctrl_slave
// Description : Control-bus responder sequencing flush, selective flush and
//               prefetch onto the tag-invalidate and refill-request ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mp_pf_icache_ctrl_slave
    import icache_ctrl_slave_pkg::*;
#(
    parameter int NB_CORES     = 8,
    parameter int NB_SETS      = 128,
    parameter int LINE_BYTES   = 16,
    parameter int MAX_PF_OUTST = 4,
    localparam int SET_W       = $clog2(NB_SETS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                bypass_req_i,
    output logic [NB_CORES:0]   bypass_ack_o,
    input  logic                flush_req_i,
    output logic                flush_ack_o,
    input  logic                sel_flush_req_i,
    input  logic [31:0]         sel_flush_addr_i,
    output logic                sel_flush_ack_o,
    input  logic                pf_req_i,
    input  logic [31:0]         pf_addr_i,
    input  logic [7:0]          pf_size_i,
    output logic                pf_ack_o,
    output logic                pf_done_o,
    input  logic [NB_CORES-1:0] core_idle_i,
    input  logic                refill_idle_i,
    output logic [NB_CORES:0]   bypass_en_o,
    output logic                inv_req_o,
    input  logic                inv_gnt_i,
    output logic                inv_all_ways_o,
    output logic [SET_W-1:0]    inv_set_o,
    output logic [31:0]         inv_addr_o,
    output logic                pf_fetch_req_o,
    input  logic                pf_fetch_gnt_i,
    output logic [31:0]         pf_fetch_addr_o,
    input  logic                pf_fetch_done_i
);

    localparam int               OFF_W    = line_off_w(LINE_BYTES);
    localparam logic [SET_W-1:0] LAST_SET = SET_W'(NB_SETS - 1);

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [SET_W-1:0]    set_q, set_d;
    logic [31:0]         sel_addr_q, sel_addr_d;
    logic                flush_ack_q, flush_ack_d;
    logic                sel_ack_q, sel_ack_d;
    logic                pf_ack_q, pf_ack_d;
    logic                pf_done_q, pf_done_d;
    logic [NB_CORES:0]   bypass_q, bypass_d;
    logic [NB_CORES:0]   port_idle;
    logic                pf_start;
    logic                pf_finished;

    assign port_idle = {refill_idle_i, core_idle_i};

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        set_d          = set_q;
        sel_addr_d     = sel_addr_q;
        pf_ack_d       = 1'b0;
        pf_start       = 1'b0;
        inv_req_o      = 1'b0;
        inv_all_ways_o = 1'b0;
        inv_set_o      = '0;
        inv_addr_o     = '0;

        // Bypass bits only follow the request while their port is quiet.
        for (int i = 0; i <= NB_CORES; i++) begin
            bypass_d[i] = port_idle[i] ? bypass_req_i : bypass_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (flush_req_i) begin
                    state_d = ST_FLUSH;
                    op_d    = OP_FLUSH;
                    set_d   = '0;
                end else if (sel_flush_req_i) begin
                    state_d    = ST_SEL;
                    op_d       = OP_SEL;
                    sel_addr_d = sel_flush_addr_i;
                end else if (pf_req_i) begin
                    op_d     = OP_PF;
                    pf_ack_d = 1'b1;
                    pf_start = 1'b1;
                    state_d  = (pf_size_i == 8'd0) ? ST_DONE : ST_PF;
                end
            end
            ST_FLUSH: begin
                inv_req_o      = 1'b1;
                inv_all_ways_o = 1'b1;
                inv_set_o      = set_q;
                inv_addr_o     = 32'(set_q) << OFF_W;
                if (inv_gnt_i) begin
                    if (set_q == LAST_SET) state_d = ST_DONE;
                    else                   set_d   = set_q + 1'b1;
                end
            end
            ST_SEL: begin
                inv_req_o  = 1'b1;
                inv_set_o  = sel_addr_q[OFF_W +: SET_W];
                inv_addr_o = sel_addr_q;
                if (inv_gnt_i) state_d = ST_DONE;
            end
            ST_PF: begin
                if (pf_finished) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        flush_ack_d = (state_d == ST_DONE) && (op_d == OP_FLUSH);
        sel_ack_d   = (state_d == ST_DONE) && (op_d == OP_SEL);
        pf_done_d   = (state_d == ST_DONE) && (op_d == OP_PF);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NONE;
            set_q       <= '0;
            sel_addr_q  <= '0;
            flush_ack_q <= 1'b0;
            sel_ack_q   <= 1'b0;
            pf_ack_q    <= 1'b0;
            pf_done_q   <= 1'b0;
            bypass_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            set_q       <= set_d;
            sel_addr_q  <= sel_addr_d;
            flush_ack_q <= flush_ack_d;
            sel_ack_q   <= sel_ack_d;
            pf_ack_q    <= pf_ack_d;
            pf_done_q   <= pf_done_d;
            bypass_q    <= bypass_d;
        end
    end

    icache_pf_sequencer #(
        .LINE_BYTES   (LINE_BYTES),
        .MAX_PF_OUTST (MAX_PF_OUTST)
    ) u_pf_seq (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (pf_start),
        .addr_i       (pf_addr_i),
        .size_i       (pf_size_i),
        .en_i         (state_q == ST_PF),
        .fetch_gnt_i  (pf_fetch_gnt_i),
        .fetch_done_i (pf_fetch_done_i),
        .fetch_req_o  (pf_fetch_req_o),
        .fetch_addr_o (pf_fetch_addr_o),
        .finished_o   (pf_finished)
    );

    assign bypass_ack_o    = bypass_q;
    assign bypass_en_o     = bypass_q;
    assign flush_ack_o     = flush_ack_q;
    assign sel_flush_ack_o = sel_ack_q;
    assign pf_ack_o        = pf_ack_q;
    assign pf_done_o       = pf_done_q;

endmodule

`default_nettype wire

// File: tb/tb_mp_pf_icache_ctrl_slave.sv
// ============================================================================
// Module      : tb_mp_pf_icache_ctrl_slave
// Description : Scoreboard bench for the icache control-bus responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mp_pf_icache_ctrl_slave;

    localparam int NB_CORES     = 8;
    localparam int NB_SETS      = 128;
    localparam int LINE_BYTES   = 16;
    localparam int MAX_PF_OUTST = 4;
    localparam int SET_W        = $clog2(NB_SETS);

    localparam int K_FLUSH = 1, K_SEL = 2, K_PFACK = 3, K_PFDONE = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                bypass_req;
    logic [NB_CORES:0]   bypass_ack, bypass_en;
    logic                flush_req, flush_ack;
    logic                sel_req, sel_ack;
    logic [31:0]         sel_addr;
    logic                pf_req, pf_ack, pf_done;
    logic [31:0]         pf_addr;
    logic [7:0]          pf_size;
    logic [NB_CORES-1:0] core_idle;
    logic                refill_idle;
    logic                inv_req, inv_gnt, inv_all;
    logic [SET_W-1:0]    inv_set;
    logic [31:0]         inv_addr;
    logic                fetch_req, fetch_gnt, fetch_done;
    logic [31:0]         fetch_addr;

    always #5 clk = ~clk;

    mp_pf_icache_ctrl_slave #(
        .NB_CORES(NB_CORES), .NB_SETS(NB_SETS),
        .LINE_BYTES(LINE_BYTES), .MAX_PF_OUTST(MAX_PF_OUTST)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .bypass_req_i(bypass_req), .bypass_ack_o(bypass_ack),
        .flush_req_i(flush_req), .flush_ack_o(flush_ack),
        .sel_flush_req_i(sel_req), .sel_flush_addr_i(sel_addr), .sel_flush_ack_o(sel_ack),
        .pf_req_i(pf_req), .pf_addr_i(pf_addr), .pf_size_i(pf_size),
        .pf_ack_o(pf_ack), .pf_done_o(pf_done),
        .core_idle_i(core_idle), .refill_idle_i(refill_idle),
        .bypass_en_o(bypass_en),
        .inv_req_o(inv_req), .inv_gnt_i(inv_gnt), .inv_all_ways_o(inv_all),
        .inv_set_o(inv_set), .inv_addr_o(inv_addr),
        .pf_fetch_req_o(fetch_req), .pf_fetch_gnt_i(fetch_gnt),
        .pf_fetch_addr_o(fetch_addr), .pf_fetch_done_i(fetch_done)
    );

    typedef struct { int kind; int cyc; } ack_t;
    typedef struct { int set; logic all; } inv_t;

    ack_t        ack_q[$];
    inv_t        inv_q[$];
    logic [31:0] fetch_q[$];
    int          due_q[$];
    ack_t        ae;
    inv_t        ie;
    logic [31:0] fe;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int pf_grants = 0;
    int pf_dones = 0;
    int s;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic ack_chk(input int k);
        if (ack_q.size() == 0) begin
            chk("ack_extra", 64'(k), 64'd0);
        end else begin
            ae = ack_q.pop_front();
            chk("ack_kind", 64'(k), 64'(ae.kind));
            if (ae.cyc >= 0) chk("ack_cyc", 64'(cyc), 64'(ae.cyc));
        end
    endtask

    // Monitor: sample at the falling edge, compare against the scoreboard.
    always @(negedge clk) begin
        if (inv_req && inv_gnt) begin
            if (inv_q.size() == 0) chk("inv_extra", 64'(inv_set), 64'hDEAD);
            else begin
                ie = inv_q.pop_front();
                chk("inv_set", 64'(inv_set), 64'(ie.set));
                chk("inv_all", 64'(inv_all), 64'(ie.all));
            end
        end
        if (fetch_req && fetch_gnt) begin
            chk("pf_outst", 64'((pf_grants - pf_dones) < MAX_PF_OUTST), 64'd1);
            pf_grants++;
            due_q.push_back(cyc + 5);
            if (fetch_q.size() == 0) chk("fetch_extra", 64'(fetch_addr), 64'hDEAD);
            else begin
                fe = fetch_q.pop_front();
                chk("fetch_addr", 64'(fetch_addr), 64'(fe));
            end
        end
        if (fetch_done) pf_dones++;
        if (flush_ack) ack_chk(K_FLUSH);
        if (sel_ack)   ack_chk(K_SEL);
        if (pf_ack)    ack_chk(K_PFACK);
        if (pf_done)   ack_chk(K_PFDONE);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            fetch_done = 1'b1;
            void'(due_q.pop_front());
        end else begin
            fetch_done = 1'b0;
        end
    endtask

    task automatic push_ack(input int k, input int c);
        ae.kind = k;
        ae.cyc  = c;
        ack_q.push_back(ae);
    endtask

    task automatic push_inv(input int set, input logic all);
        ie.set = set;
        ie.all = all;
        inv_q.push_back(ie);
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && (ack_q.size() + inv_q.size() + fetch_q.size()) != 0; i++) tick();
        chk("drain", 64'(ack_q.size() + inv_q.size() + fetch_q.size()), 64'd0);
        tick();
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, 64'({bypass_ack, bypass_en, flush_ack, sel_ack, pf_ack, pf_done,
                                inv_req, inv_all, inv_set, fetch_req}), 64'd0);
        chk({tag, "_inv_addr"}, 64'(inv_addr), 64'd0);
        chk({tag, "_fetch_addr"}, 64'(fetch_addr), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; bypass_req = 1'b0; flush_req = 1'b0; sel_req = 1'b0; sel_addr = '0;
        pf_req = 1'b0; pf_addr = '0; pf_size = '0; core_idle = '0; refill_idle = 1'b0;
        inv_gnt = 1'b0; fetch_gnt = 1'b1; fetch_done = 1'b0;

        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check_all_zero("post_reset");

        // Full flush with a constant grant.
        inv_gnt = 1'b1;
        s = cyc;
        for (int i = 0; i < NB_SETS; i++) push_inv(i, 1'b1);
        push_ack(K_FLUSH, s + NB_SETS + 1);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        drain(300);

        // Selective flush, grant held off for three cycles.
        inv_gnt = 1'b0;
        s = cyc;
        sel_addr = 32'h0000_1230;
        push_inv(32'h23, 1'b0);
        push_ack(K_SEL, s + 5);
        sel_req = 1'b1;
        tick();
        sel_req = 1'b0;
        repeat (3) tick();
        chk("sel_inv_req", 64'(inv_req), 64'd1);
        chk("sel_inv_addr", 64'(inv_addr), 64'h1230);
        inv_gnt = 1'b1;
        tick();
        inv_gnt = 1'b0;
        drain(50);
        inv_gnt = 1'b1;

        // Prefetch wrapping past the top of the address space.
        s = cyc;
        pf_addr = 32'hFFFF_FFE7;
        pf_size = 8'd4;
        fetch_q.push_back(32'hFFFF_FFE0);
        fetch_q.push_back(32'hFFFF_FFF0);
        fetch_q.push_back(32'h0000_0000);
        fetch_q.push_back(32'h0000_0010);
        push_ack(K_PFACK, s + 1);
        push_ack(K_PFDONE, -1);
        pf_req = 1'b1;
        tick();
        tick();
        pf_req = 1'b0;
        drain(100);
        chk("pf4_all_done", 64'(pf_dones), 64'd4);

        // Zero-length prefetch completes immediately.
        s = cyc;
        pf_size = 8'd0;
        push_ack(K_PFACK, s + 1);
        push_ack(K_PFDONE, s + 1);
        pf_req = 1'b1;
        tick();
        chk("pf0_no_req", 64'(fetch_req), 64'd0);
        tick();
        pf_req = 1'b0;
        drain(20);

        // Flush and prefetch together while only the low four ports are idle.
        core_idle = 8'h0F;
        refill_idle = 1'b0;
        bypass_req = 1'b1;
        tick();
        tick();
        chk("bypass_partial", 64'(bypass_ack), 64'h00F);
        chk("bypass_en_partial", 64'(bypass_en), 64'h00F);
        s = cyc;
        for (int i = 0; i < NB_SETS; i++) push_inv(i, 1'b1);
        push_ack(K_FLUSH, s + NB_SETS + 1);
        push_ack(K_PFACK, s + NB_SETS + 3);
        push_ack(K_PFDONE, -1);
        pf_addr = 32'h0000_1004;
        pf_size = 8'd6;
        for (int i = 0; i < 6; i++) fetch_q.push_back(32'h0000_1000 + 32'(i * LINE_BYTES));
        flush_req = 1'b1;
        pf_req = 1'b1;
        tick();
        flush_req = 1'b0;
        for (int i = 0; i < 300 && !pf_ack; i++) tick();
        chk("combo_pf_ack_seen", 64'(pf_ack), 64'd1);
        tick();
        pf_req = 1'b0;
        drain(100);
        chk("bypass_hold", 64'(bypass_ack), 64'h00F);
        core_idle = 8'hFF;
        refill_idle = 1'b1;
        tick();
        chk("bypass_full", 64'(bypass_ack), 64'h1FF);
        bypass_req = 1'b0;
        core_idle = 8'h00;
        refill_idle = 1'b0;
        tick();
        chk("bypass_busy_hold", 64'(bypass_en), 64'h1FF);
        core_idle = 8'hFF;
        refill_idle = 1'b1;
        tick();
        chk("bypass_clear", 64'(bypass_ack), 64'h000);

        // Reset in the middle of a flush, then a clean restart.
        s = cyc;
        for (int i = 0; i <= 40; i++) push_inv(i, 1'b1);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (40) tick();
        chk("rst_at_set40", 64'(inv_set), 64'd40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("mid_reset");
        repeat (3) tick();
        chk("mid_reset_inv_q", 64'(inv_q.size()), 64'd0);
        s = cyc;
        for (int i = 0; i < NB_SETS; i++) push_inv(i, 1'b1);
        push_ack(K_FLUSH, s + NB_SETS + 1);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        drain(300);

        chk("sb_empty", 64'(ack_q.size() + inv_q.size() + fetch_q.size() + due_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
